// File: rtl/bp_fe_icache_cce_responder_if.sv
// LCE<->CCE link plus memory fetch port as seen by the I-cache CCE responder.
// Packed layouts, MSB first: req {dst,src,type[2:0],addr,lru_way}; resp {dst,src,type[1:0],addr};
// cmd {dst,src,type[3:0],way,state[1:0],addr,data}.
interface bp_fe_icache_cce_responder_if #(
   parameter int paddr_width_p            = 40,
   parameter int lce_id_width_p           = 4,
   parameter int cce_id_width_p           = 4,
   parameter int lce_assoc_icache_p       = 8,
   parameter int cce_block_width_icache_p = 512
);
   localparam int way_width_lp          = (lce_assoc_icache_p > 1) ? $clog2(lce_assoc_icache_p) : 1;
   localparam int lce_cce_req_width_lp  = cce_id_width_p + lce_id_width_p + 3 + paddr_width_p + way_width_lp;
   localparam int lce_cce_resp_width_lp = cce_id_width_p + lce_id_width_p + 2 + paddr_width_p;
   localparam int lce_cmd_width_lp      = lce_id_width_p + cce_id_width_p + 4 + way_width_lp + 2
                                        + paddr_width_p + cce_block_width_icache_p;

   logic [lce_cce_req_width_lp-1:0]     lce_req_i;
   logic                                lce_req_v_i;
   logic                                lce_req_yumi_o;
   logic [lce_cce_resp_width_lp-1:0]    lce_resp_i;
   logic                                lce_resp_v_i;
   logic                                lce_resp_yumi_o;
   logic [lce_cmd_width_lp-1:0]         lce_cmd_o;
   logic                                lce_cmd_v_o;
   logic                                lce_cmd_yumi_i;
   logic [paddr_width_p-1:0]            mem_cmd_addr_o;
   logic                                mem_cmd_uc_o;
   logic                                mem_cmd_v_o;
   logic                                mem_cmd_ready_i;
   logic [cce_block_width_icache_p-1:0] mem_resp_data_i;
   logic                                mem_resp_v_i;
   logic                                mem_resp_yumi_o;

   modport slave (
      input  lce_req_i, lce_req_v_i, lce_resp_i, lce_resp_v_i, lce_cmd_yumi_i,
             mem_cmd_ready_i, mem_resp_data_i, mem_resp_v_i,
      output lce_req_yumi_o, lce_resp_yumi_o, lce_cmd_o, lce_cmd_v_o,
             mem_cmd_addr_o, mem_cmd_uc_o, mem_cmd_v_o, mem_resp_yumi_o
   );

   modport master (
      output lce_req_i, lce_req_v_i, lce_resp_i, lce_resp_v_i, lce_cmd_yumi_i,
             mem_cmd_ready_i, mem_resp_data_i, mem_resp_v_i,
      input  lce_req_yumi_o, lce_resp_yumi_o, lce_cmd_o, lce_cmd_v_o,
             mem_cmd_addr_o, mem_cmd_uc_o, mem_cmd_v_o, mem_resp_yumi_o
   );
endinterface

// File: rtl/bp_fe_icache_cce_responder.sv
// CCE-side responder for a single I-cache LCE: syncs the LCE after reset, then serves
// one cached block miss or uncached dword read at a time through the memory port.
module bp_fe_icache_cce_responder #(
   parameter int paddr_width_p            = 40,
   parameter int lce_id_width_p           = 4,
   parameter int cce_id_width_p           = 4,
   parameter int lce_assoc_icache_p       = 8,
   parameter int cce_block_width_icache_p = 512,
   parameter int cce_id_p                 = 0
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [lce_id_width_p-1:0] lce_id_i,
   bp_fe_icache_cce_responder_if.slave bus,
   output logic                      ready_o,
   output logic                      proto_err_o
);
   localparam int way_width_lp   = (lce_assoc_icache_p > 1) ? $clog2(lce_assoc_icache_p) : 1;
   localparam int dword_width_lp = 64;
   localparam logic [paddr_width_p-1:0] block_mask_lp =
      ~paddr_width_p'(cce_block_width_icache_p / 8 - 1);

   localparam logic [2:0] e_lce_req_type_rd  = 3'd0;
   localparam logic [2:0] e_lce_req_uc_rd    = 3'd2;
   localparam logic [1:0] e_lce_cce_sync_ack = 2'd0;
   localparam logic [1:0] e_lce_cce_coh_ack  = 2'd1;
   localparam logic [3:0] e_lce_cmd_sync     = 4'd0;
   localparam logic [3:0] e_lce_cmd_data     = 4'd1;
   localparam logic [3:0] e_lce_cmd_uc_data  = 4'd2;
   localparam logic [1:0] e_COH_I            = 2'd0;
   localparam logic [1:0] e_COH_S            = 2'd1;

   typedef struct packed {
      logic [cce_id_width_p-1:0] dst_id;
      logic [lce_id_width_p-1:0] src_id;
      logic [2:0]                msg_type;
      logic [paddr_width_p-1:0]  addr;
      logic [way_width_lp-1:0]   lru_way;
   } req_s;

   typedef struct packed {
      logic [cce_id_width_p-1:0] dst_id;
      logic [lce_id_width_p-1:0] src_id;
      logic [1:0]                msg_type;
      logic [paddr_width_p-1:0]  addr;
   } resp_s;

   typedef struct packed {
      logic [lce_id_width_p-1:0]           dst_id;
      logic [cce_id_width_p-1:0]           src_id;
      logic [3:0]                          msg_type;
      logic [way_width_lp-1:0]             way_id;
      logic [1:0]                          state;
      logic [paddr_width_p-1:0]            addr;
      logic [cce_block_width_icache_p-1:0] data;
   } cmd_s;

   typedef enum logic [2:0] {
      S_SYNC, S_SYNC_ACK, S_READY, S_MEM_CMD, S_MEM_RESP, S_SEND, S_ACK
   } state_e;

   state_e                              state_q, state_d;
   logic                                live_q, live_d;
   logic [paddr_width_p-1:0]            addr_q, addr_d;
   logic [way_width_lp-1:0]             way_q, way_d;
   logic                                uc_q, uc_d;
   logic [cce_block_width_icache_p-1:0] data_q, data_d;
   logic                                err_q, err_d;

   req_s  req;
   resp_s resp;
   cmd_s  cmd;
   logic  req_yumi, resp_yumi, cmd_v, mem_cmd_v, mem_resp_yumi, ready;
   logic  unused_fields;

   assign req           = bus.lce_req_i;
   assign resp          = bus.lce_resp_i;
   assign unused_fields = ^{req.dst_id, req.src_id, resp.dst_id, resp.src_id, resp.addr};

   // live_q holds every valid/yumi low for the first cycle out of reset, so the
   // async reset drops them immediately even though the state lands in SYNC.
   always_comb begin
      state_d       = state_q;
      live_d        = 1'b1;
      addr_d        = addr_q;
      way_d         = way_q;
      uc_d          = uc_q;
      data_d        = data_q;
      err_d         = err_q;
      req_yumi      = 1'b0;
      resp_yumi     = 1'b0;
      cmd_v         = 1'b0;
      mem_cmd_v     = 1'b0;
      mem_resp_yumi = 1'b0;
      ready         = 1'b0;
      cmd           = '0;
      cmd.dst_id    = lce_id_i;
      cmd.src_id    = cce_id_width_p'(cce_id_p);
      if (live_q) begin
         unique case (state_q)
            S_SYNC: begin
               cmd_v        = 1'b1;
               cmd.msg_type = e_lce_cmd_sync;
               if (bus.lce_cmd_yumi_i) state_d = S_SYNC_ACK;
            end
            S_SYNC_ACK: begin
               if (bus.lce_resp_v_i) begin
                  resp_yumi = 1'b1;
                  if (resp.msg_type == e_lce_cce_sync_ack) state_d = S_READY;
                  else err_d = 1'b1;
               end
            end
            S_READY: begin
               ready = 1'b1;
               if (bus.lce_resp_v_i) begin
                  resp_yumi = 1'b1;
                  err_d     = 1'b1;
               end
               if (bus.lce_req_v_i) begin
                  req_yumi = 1'b1;
                  way_d    = req.lru_way;
                  if (req.msg_type == e_lce_req_type_rd) begin
                     addr_d  = req.addr & block_mask_lp;
                     uc_d    = 1'b0;
                     state_d = S_MEM_CMD;
                  end else if (req.msg_type == e_lce_req_uc_rd) begin
                     addr_d  = req.addr;
                     uc_d    = 1'b1;
                     state_d = S_MEM_CMD;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_MEM_CMD: begin
               mem_cmd_v = 1'b1;
               if (bus.mem_cmd_ready_i) state_d = S_MEM_RESP;
            end
            S_MEM_RESP: begin
               if (bus.mem_resp_v_i) begin
                  mem_resp_yumi = 1'b1;
                  data_d        = bus.mem_resp_data_i;
                  state_d       = S_SEND;
               end
            end
            S_SEND: begin
               cmd_v    = 1'b1;
               cmd.addr = addr_q;
               if (uc_q) begin
                  cmd.msg_type = e_lce_cmd_uc_data;
                  cmd.state    = e_COH_I;
                  cmd.data     = cce_block_width_icache_p'(data_q[dword_width_lp-1:0]);
               end else begin
                  cmd.msg_type = e_lce_cmd_data;
                  cmd.way_id   = way_q;
                  cmd.state    = e_COH_S;
                  cmd.data     = data_q;
               end
               if (bus.lce_cmd_yumi_i) state_d = uc_q ? S_READY : S_ACK;
            end
            S_ACK: begin
               if (bus.lce_resp_v_i) begin
                  resp_yumi = 1'b1;
                  if (resp.msg_type == e_lce_cce_coh_ack) state_d = S_READY;
                  else err_d = 1'b1;
               end
            end
            default: state_d = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_SYNC;
         live_q  <= 1'b0;
         addr_q  <= '0;
         way_q   <= '0;
         uc_q    <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         addr_q  <= addr_d;
         way_q   <= way_d;
         uc_q    <= uc_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign bus.lce_req_yumi_o  = req_yumi;
   assign bus.lce_resp_yumi_o = resp_yumi;
   assign bus.lce_cmd_o       = cmd;
   assign bus.lce_cmd_v_o     = cmd_v;
   assign bus.mem_cmd_addr_o  = addr_q;
   assign bus.mem_cmd_uc_o    = uc_q;
   assign bus.mem_cmd_v_o     = mem_cmd_v;
   assign bus.mem_resp_yumi_o = mem_resp_yumi;
   assign ready_o             = ready;
   assign proto_err_o         = err_q;
endmodule

// File: tb/tb_bp_fe_icache_cce_responder.sv
// Directed bench for the I-cache CCE responder; expected cmds/fetches go through scoreboard queues.
module tb_bp_fe_icache_cce_responder;
   localparam int PA = 40, LW = 4, CW = 4, WW = 3, BW = 512;
   localparam int REQ_W  = CW + LW + 3 + PA + WW;
   localparam int RESP_W = CW + LW + 2 + PA;
   localparam int CMD_W  = LW + CW + 4 + WW + 2 + PA + BW;
   localparam logic [LW-1:0] LCE_ID = 4'h5;
   localparam logic [2:0] RQ_RD = 3'd0, RQ_WR = 3'd1, RQ_UC_RD = 3'd2;
   localparam logic [1:0] RS_SYNC_ACK = 2'd0, RS_COH_ACK = 2'd1;
   localparam logic [3:0] C_SYNC = 4'd0, C_DATA = 4'd1, C_UC_DATA = 4'd2;
   localparam logic [1:0] COH_I = 2'd0, COH_S = 2'd1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] lce_id;
   logic          ready, perr;
   int            checks = 0;
   int            errs = 0;
   logic [CMD_W-1:0] exp_cmd_q[$];
   logic [PA:0]      exp_mem_q[$];

   always #5 clk = ~clk;

   bp_fe_icache_cce_responder_if mif ();
   bp_fe_icache_cce_responder dut (
      .clk_i(clk), .reset_n_i(rst_n), .lce_id_i(lce_id), .bus(mif),
      .ready_o(ready), .proto_err_o(perr)
   );

   function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [PA-1:0] a,
                                               input logic [WW-1:0] w);
      return {4'h0, LCE_ID, t, a, w};
   endfunction

   function automatic logic [RESP_W-1:0] mk_resp(input logic [1:0] t);
      return {4'h0, LCE_ID, t, 40'h0};
   endfunction

   function automatic logic [CMD_W-1:0] mk_cmd(input logic [3:0] t, input logic [WW-1:0] w,
                                               input logic [1:0] st, input logic [PA-1:0] a,
                                               input logic [BW-1:0] d);
      return {LCE_ID, 4'h0, t, w, st, a, d};
   endfunction

   task automatic chk(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted lce_cmd / mem_cmd must match the queue head.
   always @(negedge clk) begin
      if (rst_n && mif.lce_cmd_v_o && mif.lce_cmd_yumi_i) begin
         if (exp_cmd_q.size() == 0) chk("lce_cmd_unexpected", CMD_W'(exp_cmd_q.size()), CMD_W'(1));
         else chk("lce_cmd", mif.lce_cmd_o, exp_cmd_q.pop_front());
      end
      if (rst_n && mif.mem_cmd_v_o && mif.mem_cmd_ready_i) begin
         if (exp_mem_q.size() == 0) chk("mem_cmd_unexpected", CMD_W'(exp_mem_q.size()), CMD_W'(1));
         else chk("mem_cmd", {mif.mem_cmd_uc_o, mif.mem_cmd_addr_o}, exp_mem_q.pop_front());
      end
   end

   task automatic take_cmd(input int stall);
      int n = 0;
      while (mif.lce_cmd_v_o !== 1'b1 && n < 100) begin tick(); n++; end
      chk("lce_cmd_wait", CMD_W'(n < 100), CMD_W'(1));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("lce_cmd_v_hold", mif.lce_cmd_v_o, 1);
         if (exp_cmd_q.size() > 0) chk("lce_cmd_hold", mif.lce_cmd_o, exp_cmd_q[0]);
      end
      mif.lce_cmd_yumi_i = 1'b1;
      tick();
      mif.lce_cmd_yumi_i = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] t, input logic [PA-1:0] a, input logic [WW-1:0] w);
      mif.lce_req_i = mk_req(t, a, w);
      mif.lce_req_v_i = 1'b1;
      #1;
      chk("lce_req_yumi", mif.lce_req_yumi_o, 1);
      tick();
      mif.lce_req_v_i = 1'b0;
   endtask

   task automatic send_resp(input logic [1:0] t);
      mif.lce_resp_i = mk_resp(t);
      mif.lce_resp_v_i = 1'b1;
      #1;
      chk("lce_resp_yumi", mif.lce_resp_yumi_o, 1);
      tick();
      mif.lce_resp_v_i = 1'b0;
   endtask

   task automatic mem_serve(input int stall, input logic [BW-1:0] data, input bit give_resp);
      int n = 0;
      while (mif.mem_cmd_v_o !== 1'b1 && n < 100) begin tick(); n++; end
      chk("mem_cmd_wait", CMD_W'(n < 100), CMD_W'(1));
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("mem_cmd_v_hold", mif.mem_cmd_v_o, 1);
         if (exp_mem_q.size() > 0) chk("mem_cmd_hold", {mif.mem_cmd_uc_o, mif.mem_cmd_addr_o}, exp_mem_q[0]);
      end
      mif.mem_cmd_ready_i = 1'b1;
      tick();
      mif.mem_cmd_ready_i = 1'b0;
      chk("mem_cmd_v_drop", mif.mem_cmd_v_o, 0);
      if (give_resp) begin
         mif.mem_resp_data_i = data;
         mif.mem_resp_v_i = 1'b1;
         #1;
         chk("mem_resp_yumi", mif.mem_resp_yumi_o, 1);
         tick();
         mif.mem_resp_v_i = 1'b0;
         mif.mem_resp_data_i = '0;
         chk("lce_cmd_latency", mif.lce_cmd_v_o, 1);
      end
   endtask

   task automatic do_sync(input bit bad_first);
      exp_cmd_q.push_back(mk_cmd(C_SYNC, '0, COH_I, '0, '0));
      take_cmd(0);
      chk("sync_ack_ready_lo", ready, 0);
      if (bad_first) begin
         send_resp(RS_COH_ACK);
         chk("bad_resp_err", perr, 1);
         chk("bad_resp_not_ready", ready, 0);
      end
      send_resp(RS_SYNC_ACK);
      chk("sync_ready", ready, 1);
   endtask

   task automatic clear_inputs();
      mif.lce_req_i = '0;       mif.lce_req_v_i = 1'b0;
      mif.lce_resp_i = '0;      mif.lce_resp_v_i = 1'b0;
      mif.lce_cmd_yumi_i = 1'b0;
      mif.mem_cmd_ready_i = 1'b0;
      mif.mem_resp_data_i = '0; mif.mem_resp_v_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] rnd;
      lce_id = LCE_ID;
      clear_inputs();
      // reset state, with request/response valids held high to prove nothing is consumed
      mif.lce_req_v_i = 1'b1; mif.lce_resp_v_i = 1'b1; mif.mem_resp_v_i = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_ready", ready, 0);
      chk("rst_perr", perr, 0);
      chk("rst_lce_cmd_v", mif.lce_cmd_v_o, 0);
      chk("rst_mem_cmd_v", mif.mem_cmd_v_o, 0);
      chk("rst_req_yumi", mif.lce_req_yumi_o, 0);
      chk("rst_resp_yumi", mif.lce_resp_yumi_o, 0);
      chk("rst_mem_resp_yumi", mif.mem_resp_yumi_o, 0);
      clear_inputs();
      tick();
      rst_n = 1'b1;

      // 1: sync handshake
      do_sync(1'b0);
      chk("sync_perr", perr, 0);

      // 2: cached read, block-aligned fetch, data cmd, ready only after coh_ack
      exp_mem_q.push_back({1'b0, 40'h00_8000_1200});
      send_req(RQ_RD, 40'h00_8000_1234, 3'd3);
      chk("rd_mem_cmd_latency", mif.mem_cmd_v_o, 1);
      chk("rd_busy", ready, 0);
      exp_cmd_q.push_back(mk_cmd(C_DATA, 3'd3, COH_S, 40'h00_8000_1200, {64{8'hA5}}));
      mem_serve(0, {64{8'hA5}}, 1'b1);
      take_cmd(0);
      chk("rd_wait_ack", ready, 0);
      tick(); tick();
      chk("rd_still_wait_ack", ready, 0);
      send_resp(RS_COH_ACK);
      chk("rd_ready_after_ack", ready, 1);

      // 3: uncached read returns the low dword only, no ack wait
      exp_mem_q.push_back({1'b1, 40'h00_0010_0008});
      send_req(RQ_UC_RD, 40'h00_0010_0008, 3'd2);
      exp_cmd_q.push_back(mk_cmd(C_UC_DATA, '0, COH_I, 40'h00_0010_0008, {448'h0, 64'hDEAD_BEEF_0BAD_F00D}));
      mem_serve(0, {{56{8'h5A}}, 64'hDEAD_BEEF_0BAD_F00D}, 1'b1);
      take_cmd(0);
      chk("uc_ready_next", ready, 1);

      // 4: back-pressure on both the memory cmd and the lce cmd
      for (int i = 0; i < BW / 32; i++) rnd[i*32 +: 32] = $urandom();
      exp_mem_q.push_back({1'b0, 40'h00_1234_5640});
      send_req(RQ_RD, 40'h00_1234_5678, 3'd5);
      exp_cmd_q.push_back(mk_cmd(C_DATA, 3'd5, COH_S, 40'h00_1234_5640, rnd));
      mem_serve(5, rnd, 1'b1);
      take_cmd(4);
      chk("bp_no_dup_cmd", mif.lce_cmd_v_o, 0);
      send_resp(RS_COH_ACK);
      chk("bp_ready", ready, 1);

      // 5: simultaneous req + stray resp in READY; then an illegal write req
      exp_mem_q.push_back({1'b1, 40'h00_0000_4010});
      mif.lce_req_i = mk_req(RQ_UC_RD, 40'h00_0000_4010, 3'd0); mif.lce_req_v_i = 1'b1;
      mif.lce_resp_i = mk_resp(RS_COH_ACK);                      mif.lce_resp_v_i = 1'b1;
      #1;
      chk("both_req_yumi", mif.lce_req_yumi_o, 1);
      chk("both_resp_yumi", mif.lce_resp_yumi_o, 1);
      tick();
      mif.lce_req_v_i = 1'b0; mif.lce_resp_v_i = 1'b0;
      chk("both_perr", perr, 1);
      chk("both_mem_cmd_v", mif.mem_cmd_v_o, 1);
      exp_cmd_q.push_back(mk_cmd(C_UC_DATA, '0, COH_I, 40'h00_0000_4010, {448'h0, 64'h0123_4567_89AB_CDEF}));
      mem_serve(0, {{56{8'hFF}}, 64'h0123_4567_89AB_CDEF}, 1'b1);
      take_cmd(0);
      send_req(RQ_WR, 40'h00_0000_2000, 3'd1);
      chk("wr_stay_ready", ready, 1);
      chk("wr_no_fetch", mif.mem_cmd_v_o, 0);
      chk("wr_perr_sticky", perr, 1);

      // 6a: reset while waiting for memory data; then a bad resp during sync
      exp_mem_q.push_back({1'b0, 40'h00_0000_3000});
      send_req(RQ_RD, 40'h00_0000_303C, 3'd2);
      mem_serve(2, '0, 1'b0);
      rst_n = 1'b0;
      #1;
      mif.mem_resp_v_i = 1'b1; mif.lce_resp_v_i = 1'b1; mif.lce_req_v_i = 1'b1;
      #1;
      chk("rst_mr_mem_resp_yumi", mif.mem_resp_yumi_o, 0);
      chk("rst_mr_req_yumi", mif.lce_req_yumi_o, 0);
      chk("rst_mr_resp_yumi", mif.lce_resp_yumi_o, 0);
      chk("rst_mr_lce_cmd_v", mif.lce_cmd_v_o, 0);
      chk("rst_mr_mem_cmd_v", mif.mem_cmd_v_o, 0);
      chk("rst_mr_ready", ready, 0);
      chk("rst_mr_perr", perr, 0);
      tick(); tick();
      clear_inputs();
      rst_n = 1'b1;
      do_sync(1'b1);
      chk("sync_bad_perr_sticky", perr, 1);

      // 6b: reset while waiting for the coherence ack
      exp_mem_q.push_back({1'b0, 40'h00_ABCD_E040});
      send_req(RQ_RD, 40'h00_ABCD_E07F, 3'd7);
      exp_cmd_q.push_back(mk_cmd(C_DATA, 3'd7, COH_S, 40'h00_ABCD_E040, {32{16'h1234}}));
      mem_serve(0, {32{16'h1234}}, 1'b1);
      take_cmd(0);
      chk("ack_wait_ready", ready, 0);
      rst_n = 1'b0;
      #1;
      mif.lce_resp_i = mk_resp(RS_COH_ACK); mif.lce_resp_v_i = 1'b1;
      #1;
      chk("rst_ack_resp_yumi", mif.lce_resp_yumi_o, 0);
      chk("rst_ack_lce_cmd_v", mif.lce_cmd_v_o, 0);
      chk("rst_ack_ready", ready, 0);
      chk("rst_ack_perr", perr, 0);
      tick();
      clear_inputs();
      rst_n = 1'b1;
      do_sync(1'b0);
      chk("final_perr", perr, 0);

      tick(); tick();
      chk("cmd_q_drained", CMD_W'(exp_cmd_q.size()), '0);
      chk("mem_q_drained", CMD_W'(exp_mem_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
